// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_pkg
// Brief    : Shared states, error codes and defaults for the UART frame decoder.
// Revision : 1.0 - initial release
// ============================================================================
package uart_frame_pkg;

   typedef enum logic [2:0] {
      HUNT    = 3'd0,
      LEN     = 3'd1,
      PAYLOAD = 3'd2,
      CSUM    = 3'd3,
      DRAIN   = 3'd4
   } state_t;

   localparam logic [1:0] ERR_BAD_LEN = 2'd1;
   localparam logic [1:0] ERR_BAD_SUM = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   localparam logic [7:0] SYNC_DEFAULT = 8'h55;

   function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
      return a + b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_buf.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_buf
// Brief    : DEPTHx8 payload store, one synchronous write and one async read.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem_q [DEPTH];

   // Contents are deliberately unreset; only validated frames are ever read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/uart_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_rx
// Brief    : Sync hunt, length-prefixed payload capture, checksum gate, replay.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_rx
   import uart_frame_pkg::*;
#(
   parameter int         MAX_LEN = 16,
   parameter logic [7:0] SYNC    = SYNC_DEFAULT,
   parameter int         TIMEOUT = 1024
) (
   input  logic       clk_4x,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       out_last,
   input  logic       out_ready,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic       overrun
);

   localparam int              AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int              CW        = $clog2(TIMEOUT + 1);
   localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [CW-1:0]   TO_LAST   = CW'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] last_idx_q, last_idx_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]    sum_q, sum_d;
   logic [CW-1:0] tmo_q, tmo_d;
   logic          frame_ok_q, frame_ok_d;
   logic          frame_err_q, frame_err_d;
   logic [1:0]    err_code_q, err_code_d;
   logic          overrun_q, overrun_d;

   logic          buf_we;
   logic [7:0]    rd_byte;
   logic          tmo_hit;
   logic          is_last;
   logic          handshake;

   uart_frame_buf #(
      .DEPTH (MAX_LEN),
      .AW    (AW)
   ) u_buf (
      .clk     (clk_4x),
      .wr_en   (buf_we),
      .wr_addr (wr_ptr_q),
      .wr_data (in_data),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_byte)
   );

   // The counter holds 1 in the cycle after an accepted byte, so it reads
   // "cycles since the strobe" and expiry lands TIMEOUT cycles later.
   assign tmo_hit   = (tmo_q >= TO_LAST);
   assign out_valid = (state_q == DRAIN);
   assign is_last   = (rd_ptr_q == last_idx_q);
   assign out_last  = out_valid && is_last;
   assign out_data  = out_valid ? rd_byte : 8'h00;
   assign handshake = out_valid && out_ready;

   always_comb begin
      state_d     = state_q;
      last_idx_d  = last_idx_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      sum_d       = sum_q;
      tmo_d       = tmo_q;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = 2'd0;
      overrun_d   = 1'b0;
      buf_we      = 1'b0;

      if ((state_q == LEN || state_q == PAYLOAD || state_q == CSUM) && !in_valid) begin
         if (tmo_hit) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            state_d     = HUNT;
            tmo_d       = '0;
         end else begin
            tmo_d = tmo_q + CW'(1);
         end
      end

      case (state_q)
         HUNT: begin
            tmo_d = '0;
            if (in_valid && in_data == SYNC) begin
               state_d = LEN;
               tmo_d   = CW'(1);
            end
         end
         LEN: begin
            if (in_valid) begin
               if (in_data == 8'h00 || in_data > MAX_LEN_B) begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_BAD_LEN;
                  state_d     = HUNT;
                  tmo_d       = '0;
               end else begin
                  last_idx_d = AW'(in_data - 8'd1);
                  sum_d      = in_data;
                  wr_ptr_d   = '0;
                  state_d    = PAYLOAD;
                  tmo_d      = CW'(1);
               end
            end
         end
         PAYLOAD: begin
            if (in_valid) begin
               buf_we   = 1'b1;
               sum_d    = sum8(sum_q, in_data);
               wr_ptr_d = wr_ptr_q + AW'(1);
               tmo_d    = CW'(1);
               if (wr_ptr_q == last_idx_q) begin
                  state_d = CSUM;
               end
            end
         end
         CSUM: begin
            if (in_valid) begin
               tmo_d = '0;
               if (sum8(sum_q, in_data) == 8'h00) begin
                  frame_ok_d = 1'b1;
                  rd_ptr_d   = '0;
                  state_d    = DRAIN;
               end else begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_BAD_SUM;
                  state_d     = HUNT;
               end
            end
         end
         DRAIN: begin
            // No backpressure upstream: anything arriving now is lost.
            if (in_valid) begin
               overrun_d = 1'b1;
            end
            if (handshake) begin
               rd_ptr_d = rd_ptr_q + AW'(1);
               if (is_last) begin
                  state_d = HUNT;
               end
            end
         end
         default: begin
            state_d = HUNT;
         end
      endcase
   end

   always_ff @(posedge clk_4x or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= HUNT;
         last_idx_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         sum_q       <= 8'h00;
         tmo_q       <= '0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= 2'd0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_idx_q  <= last_idx_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         sum_q       <= sum_d;
         tmo_q       <= tmo_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
         overrun_q   <= overrun_d;
      end
   end

   assign frame_ok  = frame_ok_q;
   assign frame_err = frame_err_q;
   assign err_code  = err_code_q;
   assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_rx
// Brief    : Scoreboard bench for uart_frame_rx frame decode and replay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_rx;

   localparam int TIMEOUT = 100;

   logic       clk_4x = 1'b0;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_last;
   logic       out_ready;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;
   logic       overrun;

   uart_frame_rx #(
      .MAX_LEN (16),
      .SYNC    (8'h55),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk_4x    (clk_4x),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .err_code  (err_code),
      .overrun   (overrun)
   );

   always #5 clk_4x = ~clk_4x;

   int cyc = 0;
   always @(posedge clk_4x) cyc <= cyc + 1;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [8:0] exp_q[$];
   logic [7:0] tx[$];
   int         n_ok = 0, n_err = 0, n_ovr = 0, n_vcyc = 0, err_cyc = 0;
   logic [1:0] last_code = 2'd0;
   bit         prev_stall = 1'b0;
   int         strobe_cyc = 0;
   int         s_ok, s_err, s_ovr, s_vc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk_4x);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      in_data    = b;
      in_valid   = 1'b1;
      strobe_cyc = cyc;
      @(posedge clk_4x);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_tx();
      for (int i = 0; i < tx.size(); i++) send_byte(tx[i]);
      tx.delete();
   endtask

   // Builds a well-formed frame in tx and queues its payload as expected output.
   task automatic good_frame(input int len, input int seed);
      logic [7:0] s;
      logic [7:0] b;
      s = 8'(len);
      tx.push_back(8'h55);
      tx.push_back(8'(len));
      for (int i = 0; i < len; i++) begin
         b = 8'(seed + i * 37);
         tx.push_back(b);
         exp_q.push_back({(i == len - 1), b});
         s = s + b;
      end
      tx.push_back(8'h00 - s);
   endtask

   task automatic snap();
      s_ok  = n_ok;
      s_err = n_err;
      s_ovr = n_ovr;
      s_vc  = n_vcyc;
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      repeat (2) @(negedge clk_4x);
      while ((exp_q.size() != 0 || out_valid) && k < 400) begin
         @(negedge clk_4x);
         k++;
      end
      if (k >= 400) chk({tag, "_idle_budget"}, 32'd0, 32'd1);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_valid"}, out_valid, 1'b0);
      chk({tag, "_last"},  out_last,  1'b0);
      chk({tag, "_ok"},    frame_ok,  1'b0);
      chk({tag, "_err"},   frame_err, 1'b0);
      chk({tag, "_ovr"},   overrun,   1'b0);
      chk({tag, "_code"},  err_code,  2'd0);
      chk({tag, "_data"},  out_data,  8'h00);
   endtask

   always @(negedge clk_4x) begin
      if (rst_n === 1'b1) begin
         if (frame_ok) begin
            n_ok++;
            chk("valid_with_ok", out_valid, 1'b1);
         end
         if (frame_err) begin
            n_err++;
            last_code = err_code;
            err_cyc   = cyc;
         end
         if (overrun) n_ovr++;
         if (out_valid) n_vcyc++;
         if (prev_stall) chk("stall_valid", out_valid, 1'b1);
         if (out_valid && exp_q.size() != 0) begin
            chk("head_data", out_data, exp_q[0][7:0]);
            chk("head_last", out_last, exp_q[0][8]);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("extra_output", 32'd1, 32'd0);
            else void'(exp_q.pop_front());
         end
         prev_stall = out_valid && !out_ready;
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int s;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b1;
      repeat (3) @(posedge clk_4x);
      @(negedge clk_4x);
      chk_quiet("reset");
      @(posedge clk_4x);
      #1 rst_n = 1'b1;
      cycles(1);

      // Good two-byte frame
      snap();
      tx = '{8'h55, 8'h02, 8'h10, 8'h20, 8'hCE};
      exp_q.push_back({1'b0, 8'h10});
      exp_q.push_back({1'b1, 8'h20});
      send_tx();
      wait_idle("good");
      chk("good_ok",   n_ok - s_ok,   1);
      chk("good_err",  n_err - s_err, 0);
      chk("good_vcyc", n_vcyc - s_vc, 2);

      // Bad checksum, then a frame whose checksum equals SYNC
      snap();
      tx = '{8'h55, 8'h02, 8'h10, 8'h20, 8'hCF};
      send_tx();
      wait_idle("badsum");
      chk("badsum_err",  n_err - s_err, 1);
      chk("badsum_code", last_code, 2'd2);
      chk("badsum_ok",   n_ok - s_ok, 0);
      chk("badsum_vcyc", n_vcyc - s_vc, 0);
      snap();
      tx = '{8'h55, 8'h01, 8'hAA, 8'h55};
      exp_q.push_back({1'b1, 8'hAA});
      send_tx();
      wait_idle("after_bad");
      chk("after_bad_ok", n_ok - s_ok, 1);

      // Length limits
      snap();
      tx = '{8'h55, 8'h00};
      send_tx();
      wait_idle("len0");
      chk("len0_err",  n_err - s_err, 1);
      chk("len0_code", last_code, 2'd1);
      snap();
      tx = '{8'h55, 8'h11};
      send_tx();
      wait_idle("len17");
      chk("len17_err",  n_err - s_err, 1);
      chk("len17_code", last_code, 2'd1);
      snap();
      good_frame(16, 3);
      send_tx();
      wait_idle("len16");
      chk("len16_ok",   n_ok - s_ok, 1);
      chk("len16_err",  n_err - s_err, 0);
      chk("len16_vcyc", n_vcyc - s_vc, 16);

      // Backpressure with an overrun byte during the drain
      snap();
      out_ready = 1'b0;
      tx = '{8'h55, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF7};
      exp_q.push_back({1'b0, 8'h01});
      exp_q.push_back({1'b0, 8'h02});
      exp_q.push_back({1'b1, 8'h03});
      send_tx();
      cycles(1);
      send_byte(8'h55);
      cycles(3);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
         out_ready = ~out_ready;
         cycles(1);
      end
      out_ready = 1'b1;
      wait_idle("bp");
      chk("bp_ok",  n_ok - s_ok, 1);
      chk("bp_ovr", n_ovr - s_ovr, 1);
      chk("bp_err", n_err - s_err, 0);

      // Inter-byte timeout
      snap();
      tx = '{8'h55, 8'h04, 8'h11};
      send_tx();
      s = strobe_cyc;
      cycles(TIMEOUT + 10);
      chk("tmo_err",     n_err - s_err, 1);
      chk("tmo_code",    last_code, 2'd3);
      chk("tmo_latency", err_cyc - s, TIMEOUT);

      // Reset in the middle of a payload
      snap();
      tx = '{8'h55, 8'h04, 8'h11, 8'h22};
      send_tx();
      rst_n = 1'b0;
      @(negedge clk_4x);
      chk_quiet("midrst");
      cycles(2);
      rst_n = 1'b1;
      cycles(TIMEOUT + 10);
      chk("midrst_err", n_err - s_err, 0);
      chk("midrst_ok",  n_ok - s_ok, 0);
      snap();
      tx = '{8'h55, 8'h01, 8'hAA, 8'h55};
      exp_q.push_back({1'b1, 8'hAA});
      send_tx();
      wait_idle("post_rst");
      chk("post_rst_ok", n_ok - s_ok, 1);

      // Leading noise and 8-bit sum wrap
      snap();
      tx = '{8'h00, 8'hFF, 8'h55, 8'h01, 8'h80, 8'h80};
      send_tx();
      wait_idle("wrap_bad");
      chk("wrap_bad_err",  n_err - s_err, 1);
      chk("wrap_bad_code", last_code, 2'd2);
      chk("wrap_bad_ok",   n_ok - s_ok, 0);
      snap();
      tx = '{8'h55, 8'h01, 8'h80, 8'h7F};
      exp_q.push_back({1'b1, 8'h80});
      send_tx();
      wait_idle("wrap_good");
      chk("wrap_good_ok",  n_ok - s_ok, 1);
      chk("wrap_good_err", n_err - s_err, 0);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_frame_rx.md
# uart_frame_rx

Frame decoder that sits directly downstream of the UART receiver and consumes its one-cycle byte strobes. It hunts for a sync byte, collects a length-prefixed payload into a local buffer and verifies an 8-bit checksum. Only after the checksum passes does it replay the payload to the consumer over a valid/ready stream. Bad frames are reported and discarded without emitting any payload.

## Interface
- `MAX_LEN`, default 16: maximum payload bytes; the buffer depth.
- `SYNC`, default 8'h55: frame start byte.
- `TIMEOUT`, default 1024: inter-byte timeout in clk_4x cycles.

- `clk_4x`  input  1  the UART 4x clock; the only clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_data`  input  8  received byte; sampled only when `in_valid`=1.
- `in_valid`  input  1  single-cycle byte strobe; no backpressure.
- `out_data`  output  8  payload byte.
- `out_valid`  output  1  payload byte available.
- `out_last`  output  1  `out_data` is the final payload byte of the frame.
- `out_ready`  input  1  consumer accepts the byte.
- `frame_ok`  output  1  one-cycle pulse: checksum passed.
- `frame_err`  output  1  one-cycle pulse: frame discarded.
- `err_code`  output  2  meaningful only with `frame_err`: 1 BAD_LEN, 2 BAD_SUM, 3 TIMEOUT.
- `overrun`  output  1  one-cycle pulse: a byte arrived during DRAIN and was dropped.

## Operation
- The frame format on the wire is SYNC, LEN, payload[LEN], CSUM.
- A frame is valid when (LEN + Σpayload + CSUM) mod 256 = 0. All sums are 8-bit with wrap-around.
- State behaviour:
  - **HUNT:** a byte equal to `SYNC` moves to LEN. Any other byte is ignored silently.
  - **LEN:**
    - LEN = 0 or LEN > `MAX_LEN`: pulse `frame_err` with code 1, go to HUNT.
    - Otherwise: latch LEN, set sum = LEN, set wr_ptr = 0, go to PAYLOAD.
  - **PAYLOAD:** each byte is written to buf[wr_ptr], sum += byte, wr_ptr++. On the byte where wr_ptr = LEN-1, go to CSUM.
  - **CSUM:**
    - (sum + byte) mod 256 = 0: pulse `frame_ok`, set rd_ptr = 0, go to DRAIN.
    - Otherwise: pulse `frame_err` with code 2, go to HUNT.
  - **DRAIN:**
    - `out_valid` = 1, `out_data` = buf[rd_ptr], `out_last` = (rd_ptr == LEN-1).
    - When `out_valid`&`out_ready`: rd_ptr++. The handshake with `out_last`=1 returns to HUNT.
    - Any `in_valid` in DRAIN drops the byte and pulses `overrun`. A SYNC byte arriving in DRAIN is also lost.
- **Timeout:** in LEN, PAYLOAD or CSUM, a counter counts cycles since the last accepted byte. Reaching `TIMEOUT` pulses `frame_err` with code 3 and returns to HUNT. The counter clears on every accepted byte and on entry to HUNT.
- A SYNC value inside LEN, PAYLOAD or CSUM is treated as data; there is no resynchronisation mid-frame.

## Timing
- Reset values: state HUNT; `out_valid`, `out_last`, `frame_ok`, `frame_err`, `overrun` = 0; `err_code` = 0; `out_data` = 0.
- Buffer contents are not reset.
- Reset mid-frame or mid-drain aborts immediately. The aborted frame produces no pulse.
- All pulses are registered and high for exactly one cycle, in the cycle after the edge that accepted the triggering byte or expired the timer.
- `out_valid` first rises in the same cycle as `frame_ok`.
- The `out_data`/`out_last` pair is stable while `out_valid`=1 and `out_ready`=0. `out_valid` never drops without a handshake except on reset.
- Drain throughput is one byte per cycle with `out_ready` held high. With `out_ready` held high, `out_valid` is high for exactly LEN cycles.
- Simultaneous `in_valid` and timeout expiry: the byte wins and the timer clears.
- `in_valid` on consecutive cycles is accepted each cycle.

## Structure
- Package `uart_frame_pkg` holds:
  - the state enum: HUNT, LEN, PAYLOAD, CSUM, DRAIN;
  - the error code constants: ERR_BAD_LEN = 1, ERR_BAD_SUM = 2, ERR_TIMEOUT = 3;
  - the default SYNC value.
- Sub-module `uart_frame_buf` is a `MAX_LEN`x8 register file with one synchronous write port and one combinational read port. It has no reset.
- The FSM, sum, pointers and timeout counter stay in `uart_frame_rx`.

## Test plan
- **Good frame:** bytes 55 02 10 20 CE with `out_ready`=1.
  - `frame_ok` pulses once.
  - `out_data` is 10 then 20; `out_last` is high on 20 only; no `frame_err`.
- **Bad checksum:** bytes 55 02 10 20 CF.
  - `frame_err` with `err_code`=2; `out_valid` never rises; next frame 55 01 AA 55 is accepted.
- **Length limits:**
  - 55 00: `frame_err` code 1.
  - 55 11 (17): `frame_err` code 1.
  - 55 10 followed by 16 bytes and a correct CSUM: 16-byte drain.
- **Backpressure and overrun:** good 3-byte frame, `out_ready` low 5 cycles then toggling.
  - Data is held stable while stalled; all 3 bytes delivered in order.
  - A byte strobed during DRAIN gives one `overrun` pulse; delivered data is unchanged.
- **Timeout and reset:**
  - 55 04 11 then silence: `frame_err` code 3 exactly `TIMEOUT` cycles after the 11 strobe.
  - Separately, `rst_n` asserted mid-PAYLOAD: all outputs 0, HUNT, no pulses.
- **Noise and sum wrap:** bytes 00 FF 55 01 80 80.
  - Leading bytes are ignored.
  - 01+80+80 = 0x101 ≠ 0 mod 256, so `frame_err` code 2.
  - 55 01 80 7F passes.
